clk_gate_ctrl: RTL and testbench

Sequencer that drives the enable of one clock-gate cell (`tech_cg`) for a subsystem clock domain. It runs on the free-running clock and gates the domain only when software permits it and the domain has reported idle for a programmable hysteresis window. It ungates on a wake event or when permission is withdrawn, and it reports "clock active" only after a settle window. It sits in the SoC clock/reset control area, next to each gated subsystem.

---
 rtl/clk_gate_pkg.sv | 40 ++++
 rtl/clk_gate_ctrl.sv | 104 ++++++++++
 tb/tb_clk_gate_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/clk_gate_pkg.sv
// Shared types and helpers for the clock-gate enable sequencer.
// Holds the FSM state encoding, the registered output bundle and the counter sizing.
package clk_gate_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        IDLE_WAIT = 2'd1,
        GATED     = 2'd2,
        WAKING    = 2'd3
    } cg_state_e;

    typedef struct packed {
        logic en;
        logic active;
        logic gated;
    } cg_out_t;

    localparam cg_out_t CG_OUT_RESET = '{en: 1'b1, active: 1'b1, gated: 1'b0};

    // The counter has to hold the larger of the two windows without wrapping.
    function automatic int cg_cnt_width(input int idle_cycles, input int wake_cycles);
        int max_cycles;
        max_cycles = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
        return (max_cycles < 1) ? 1 : $clog2(max_cycles + 1);
    endfunction

    function automatic cg_out_t cg_outputs(input cg_state_e state);
        cg_out_t o;
        o = CG_OUT_RESET;
        case (state)
            RUN:       o = '{en: 1'b1, active: 1'b1, gated: 1'b0};
            IDLE_WAIT: o = '{en: 1'b1, active: 1'b1, gated: 1'b0};
            GATED:     o = '{en: 1'b0, active: 1'b0, gated: 1'b1};
            WAKING:    o = '{en: 1'b1, active: 1'b0, gated: 1'b0};
            default:   o = CG_OUT_RESET;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/clk_gate_ctrl.sv
// Drives the enable of one clock-gate cell: gates after an idle hysteresis window,
// ungates on wake or loss of permission, and flags the clock active after a settle window.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic gate_req_i,
    input  logic idle_i,
    input  logic wake_i,
    output logic cg_en_o,
    output logic clk_active_o,
    output logic gated_o
);

    localparam int CW = cg_cnt_width(IDLE_CYCLES, WAKE_CYCLES);
    localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
    localparam logic [CW-1:0] WAKE_LAST = CW'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    cg_state_e      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    cg_out_t        out_q, out_d;
    logic           qualify;
    logic           exit_gated;

    assign qualify    = gate_req_i & idle_i & ~wake_i;
    assign exit_gated = wake_i | ~gate_req_i;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                cnt_d = '0;
                if (qualify) begin
                    if (IDLE_CYCLES == 1) begin
                        state_d = GATED;
                    end else begin
                        state_d = IDLE_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            // Any drop of the qualify condition restarts the whole window from RUN.
            IDLE_WAIT: begin
                if (!qualify) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q == IDLE_LAST) begin
                    state_d = GATED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            GATED: begin
                if (exit_gated) begin
                    state_d = (WAKE_CYCLES == 0) ? RUN : WAKING;
                    cnt_d   = '0;
                end
            end
            WAKING: begin
                if (cnt_q == WAKE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
        out_d = cg_outputs(state_d);
    end

    // Reset forces the enable high at once; the cell latch only samples while clk is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            out_q   <= CG_OUT_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign cg_en_o      = out_q.en;
    assign clk_active_o = out_q.active;
    assign gated_o      = out_q.gated;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboarded bench for clk_gate_ctrl: a 4/2 build for the main sequences and a
// 1/0 build for the degenerate windows, plus a behavioural latch-based gate cell.
module tb_clk_gate_ctrl;

    // Outputs are packed {en, active, gated}; inputs are packed {gate_req, idle, wake}.
    localparam logic [2:0] O_RUN  = 3'b110;
    localparam logic [2:0] O_GAT  = 3'b001;
    localparam logic [2:0] O_WAK  = 3'b100;
    localparam logic [2:0] I_NONE = 3'b000;
    localparam logic [2:0] I_Q    = 3'b110;
    localparam logic [2:0] I_QW   = 3'b111;
    localparam logic [2:0] I_NOID = 3'b100;
    localparam logic [2:0] I_NORQ = 3'b010;
    localparam logic [2:0] I_WREL = 3'b011;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic gr_a, id_a, wk_a, en_a, act_a, gat_a;
    logic gr_b, id_b, wk_b, en_b, act_b, gat_b;

    clk_gate_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .gate_req_i(gr_a), .idle_i(id_a), .wake_i(wk_a),
        .cg_en_o(en_a), .clk_active_o(act_a), .gated_o(gat_a)
    );

    clk_gate_ctrl #(.IDLE_CYCLES(1), .WAKE_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .gate_req_i(gr_b), .idle_i(id_b), .wake_i(wk_b),
        .cg_en_o(en_b), .clk_active_o(act_b), .gated_o(gat_b)
    );

    logic en_l;
    logic gclk;
    always_latch begin
        if (!clk) en_l = en_a;
    end
    assign gclk = clk & en_l;

    int total = 0;
    int bad = 0;
    int cyc_cnt = 0;
    logic [18:0] exp_q[$];
    logic [18:0] exp_b_q[$];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got en/active/gated=%b expected %b (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    task automatic stale(input string name, input logic [18:0] e);
        total++;
        bad++;
        $display("FAIL %s: entry for cycle %0d not checked, now cycle %0d, expected %b",
                 name, e[18:3], cyc_cnt, e[2:0]);
    endtask

    // Monitor: each entry is tagged with the edge after which it must hold.
    always @(negedge clk) begin
        logic [18:0] e;
        if (exp_q.size() != 0) begin
            if (exp_q[0][18:3] == 16'(cyc_cnt)) begin
                e = exp_q.pop_front();
                check($sformatf("a_cyc%0d", e[18:3]), {en_a, act_a, gat_a}, e[2:0]);
            end else if (exp_q[0][18:3] < 16'(cyc_cnt)) begin
                e = exp_q.pop_front();
                stale("a_stale", e);
            end
        end
        if (exp_b_q.size() != 0) begin
            if (exp_b_q[0][18:3] == 16'(cyc_cnt)) begin
                e = exp_b_q.pop_front();
                check($sformatf("b_cyc%0d", e[18:3]), {en_b, act_b, gat_b}, e[2:0]);
            end else if (exp_b_q[0][18:3] < 16'(cyc_cnt)) begin
                e = exp_b_q.pop_front();
                stale("b_stale", e);
            end
        end
    end

    task automatic step_a(input logic [2:0] in, input logic [2:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            {gr_a, id_a, wk_a} = in;
            exp_q.push_back({16'(cyc_cnt + 1), exp});
        end
    endtask

    task automatic step_b(input logic [2:0] in, input logic [2:0] exp);
        @(posedge clk);
        #1;
        {gr_b, id_b, wk_b} = in;
        exp_b_q.push_back({16'(cyc_cnt + 1), exp});
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (exp_q.size() != 0 || exp_b_q.size() != 0); i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        {gr_a, id_a, wk_a} = I_NONE;
        {gr_b, id_b, wk_b} = I_NONE;
        #2 rst_n = 1'b0;
        #1;
        check("reset_a", {en_a, act_a, gat_a}, O_RUN);
        check("reset_b", {en_b, act_b, gat_b}, O_RUN);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Idle after reset, then a full gating window.
        step_a(I_NONE, O_RUN, 3);
        step_a(I_Q, O_RUN, 3);
        step_a(I_Q, O_GAT, 3);

        // Wake pulse; a second wake inside WAKING changes nothing.
        step_a(I_QW, O_WAK, 1);
        step_a(I_QW, O_WAK, 1);
        step_a(I_Q, O_RUN, 1);
        step_a(I_Q, O_RUN, 3);
        step_a(I_Q, O_GAT, 1);

        // Permission withdrawn while gated.
        step_a(I_NORQ, O_WAK, 2);
        step_a(I_NORQ, O_RUN, 1);

        // One-cycle idle drop restarts the window.
        step_a(I_Q, O_RUN, 2);
        step_a(I_NOID, O_RUN, 1);
        step_a(I_Q, O_RUN, 3);
        step_a(I_Q, O_GAT, 1);

        // Wake and permission loss together give one exit.
        step_a(I_WREL, O_WAK, 1);
        step_a(I_NONE, O_WAK, 1);
        step_a(I_NONE, O_RUN, 1);

        // Wake held with idle and permission never gates; wake aborts a count.
        step_a(I_QW, O_RUN, 6);
        step_a(I_Q, O_RUN, 3);
        step_a(I_QW, O_RUN, 1);
        step_a(I_Q, O_RUN, 3);
        step_a(I_Q, O_GAT, 2);
        drain();

        // Asynchronous reset in the high phase while gated.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_a", {en_a, act_a, gat_a}, O_RUN);
        check("rst_async_b", {en_b, act_b, gat_b}, O_RUN);
        check("no_runt_gclk", {2'b00, gclk}, 3'b000);
        @(negedge clk);
        {gr_a, id_a, wk_a} = I_NONE;
        rst_n = 1'b1;
        step_a(I_NONE, O_RUN, 2);

        // Single-cycle idle window and zero settle window.
        step_b(I_NONE, O_RUN);
        step_b(I_Q, O_GAT);
        step_b(I_Q, O_GAT);
        step_b(I_NOID, O_GAT);
        step_b(I_QW, O_RUN);
        step_b(I_Q, O_GAT);
        step_b(I_NORQ, O_RUN);
        step_b(I_NORQ, O_RUN);
        drain();

        total++;
        if (exp_q.size() != 0 || exp_b_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d/%0d entries left expected 0/0", exp_q.size(), exp_b_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
